fpga2_bist_ctrl: RTL and testbench

Built-in self-test controller for the `fpga2` self-checking datapath. On request it drives all 16 patterns of the 4-bit `{a,b,c,d}` input in ascending order and waits a programmable settle time after each one. It then samples the two-rail checker pair `{x,y}` and records the error count and the first failing pattern. It sits between the system control logic and `fpga2`, and is the only driver of `fpga2` inputs while a test is in progress.

---
 rtl/fpga2_bist_ctrl_if.sv | 38 +++
 rtl/fpga2_bist_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fpga2_bist_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga2_bist_ctrl_if.sv
// Interface between the fpga2 BIST controller, the system control logic and the fpga2 datapath.
// The signature field exists only when FPGA2_BIST_SIG_EN is defined.
interface fpga2_bist_ctrl_if #(
  parameter int ERR_W = 5
);
  logic             start;
  logic             abort;
  logic [3:0]       dut_in;
  logic [6:0]       dut_seg;
  logic [2:0]       dut_efg;
  logic [1:0]       dut_xy;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       first_fail_vec;
  logic             first_fail_valid;
`ifdef FPGA2_BIST_SIG_EN
  logic [15:0]      signature;
`endif

  // System side plus the fpga2 responses.
  modport master (
`ifdef FPGA2_BIST_SIG_EN
    input  signature,
`endif
    output start, abort, dut_seg, dut_efg, dut_xy,
    input  dut_in, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
  );

  modport slave (
`ifdef FPGA2_BIST_SIG_EN
    output signature,
`endif
    input  start, abort, dut_seg, dut_efg, dut_xy,
    output dut_in, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/fpga2_bist_ctrl.sv
// BIST controller for fpga2: sweeps all 16 input patterns, checks the two-rail {x,y} pair per pattern.
// Optional MISR over all fpga2 outputs is enabled with the FPGA2_BIST_SIG_EN macro.
module fpga2_bist_ctrl #(
  parameter int SETTLE = 4,
  parameter int ERR_W  = 5
) (
  input logic               clk,
  input logic               rst,
  fpga2_bist_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam int                WAIT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [3:0]        pat_q, pat_d;
  logic [3:0]        dut_in_q, dut_in_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [3:0]        ff_vec_q, ff_vec_d;
  logic              ff_valid_q, ff_valid_d;
  logic              pass_q, pass_d;
  logic              xy_err;
`ifdef FPGA2_BIST_SIG_EN
  logic [15:0]       sig_q, sig_d;
`else
  logic              unused_resp;
  assign unused_resp = ^{bus.dut_seg, bus.dut_efg};
`endif

  // Two-rail codes 00 and 11 mean the checker has detected a fault.
  assign xy_err = (bus.dut_xy[1] == bus.dut_xy[0]);

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    dut_in_d   = dut_in_q;
    wait_d     = wait_q;
    err_cnt_d  = err_cnt_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    pass_d     = pass_q;
`ifdef FPGA2_BIST_SIG_EN
    sig_d      = sig_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = S_APPLY;
          pat_d      = 4'd0;
          dut_in_d   = 4'd0;
          err_cnt_d  = '0;
          ff_valid_d = 1'b0;
          pass_d     = 1'b0;
`ifdef FPGA2_BIST_SIG_EN
          sig_d      = 16'hFFFF;
`endif
        end
      end
      S_APPLY: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (xy_err) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (!ff_valid_q) begin
            ff_vec_d   = pat_q;
            ff_valid_d = 1'b1;
          end
        end
`ifdef FPGA2_BIST_SIG_EN
        sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
              ^ {4'b0000, bus.dut_seg, bus.dut_efg, bus.dut_xy};
`endif
        pat_d = pat_q + 4'd1;
        if (pat_q == 4'd15) begin
          state_d = S_DONE;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d  = S_APPLY;
          dut_in_d = pat_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over any progress made in the current busy cycle.
    if (bus.abort && (state_q == S_APPLY || state_q == S_WAIT || state_q == S_SAMPLE)) begin
      state_d    = S_IDLE;
      dut_in_d   = 4'd0;
      pat_d      = pat_q;
      wait_d     = wait_q;
      err_cnt_d  = err_cnt_q;
      ff_vec_d   = ff_vec_q;
      ff_valid_d = ff_valid_q;
      pass_d     = pass_q;
`ifdef FPGA2_BIST_SIG_EN
      sig_d      = sig_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pat_q      <= 4'd0;
      dut_in_q   <= 4'd0;
      wait_q     <= '0;
      err_cnt_q  <= '0;
      ff_vec_q   <= 4'd0;
      ff_valid_q <= 1'b0;
      pass_q     <= 1'b0;
`ifdef FPGA2_BIST_SIG_EN
      sig_q      <= 16'hFFFF;
`endif
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      dut_in_q   <= dut_in_d;
      wait_q     <= wait_d;
      err_cnt_q  <= err_cnt_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
      pass_q     <= pass_d;
`ifdef FPGA2_BIST_SIG_EN
      sig_q      <= sig_d;
`endif
    end
  end

  assign bus.dut_in           = dut_in_q;
  assign bus.busy             = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign bus.done             = (state_q == S_DONE);
  assign bus.pass             = pass_q;
  assign bus.err_cnt          = err_cnt_q;
  assign bus.first_fail_vec   = ff_vec_q;
  assign bus.first_fail_valid = ff_valid_q;
`ifdef FPGA2_BIST_SIG_EN
  assign bus.signature        = sig_q;
`endif

endmodule

// File: tb/tb_fpga2_bist_ctrl.sv
// Self-checking bench for fpga2_bist_ctrl: a behavioural fpga2 with injectable faults, per-cycle
// expectations derived from the pattern schedule, and MISR checks when FPGA2_BIST_SIG_EN is defined.
module tb_fpga2_bist_ctrl;

  localparam int SETTLE    = 4;
  localparam int ERR_W     = 3;
  localparam int PER       = SETTLE + 2;
  localparam int LAST_BUSY = 16 * PER;
  localparam int DONE_CYC  = LAST_BUSY + 1;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;

  logic        clk;
  logic        rst;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] fault_mask;
  logic [1:0]  fault_xy [16];
  logic        flip_en;
  logic [3:0]  flip_pat;
  logic [15:0] resp_word;

  fpga2_bist_ctrl_if #(.ERR_W(ERR_W)) bus ();

  fpga2_bist_ctrl #(.SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural fpga2: fault-free patterns return a valid two-rail code, faulty ones 00 or 11.
  function automatic logic [15:0] fpga2_word(input logic [3:0] v, input logic faulty,
                                             input logic [1:0] bad_xy, input logic flip);
    logic [6:0] seg;
    logic [2:0] efg;
    logic [1:0] xy;
    logic       par;
    seg = {v, v[2:0]} ^ 7'h2B;
    efg = v[3:1] ^ v[2:0];
    par = ^v;
    xy  = faulty ? bad_xy : {par, ~par};
    if (flip) seg[0] = ~seg[0];
    return {4'b0000, seg, efg, xy};
  endfunction

  always_comb begin
    resp_word   = fpga2_word(bus.dut_in, fault_mask[bus.dut_in], fault_xy[bus.dut_in],
                             flip_en && (bus.dut_in == flip_pat));
    bus.dut_seg = resp_word[11:5];
    bus.dut_efg = resp_word[4:2];
    bus.dut_xy  = resp_word[1:0];
  end

`ifdef FPGA2_BIST_SIG_EN
  function automatic logic [15:0] expected_sig();
    logic [15:0] sig;
    sig = 16'hFFFF;
    for (int p = 0; p < 16; p++) begin
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)
          ^ fpga2_word(4'(p), fault_mask[p], fault_xy[p], flip_en && (4'(p) == flip_pat));
    end
    return sig;
  endfunction
`endif

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One run: start at edge 0, optional abort / repeated start / reset at given cycles (0 = none).
  task automatic applyStimulus(input logic [15:0] mask, input bit all_zero_xy, input int abort_at,
                               input int restart_at, input int rst_at);
    int  stop_at;
    bit  cut;
    bit  was_rst;
    int  exp_err;
    bit  exp_valid;
    int  exp_vec;
    int  sc;
    bit  exp_pass;
    logic [15:0] exp_sig;
    fault_mask = mask;
    for (int p = 0; p < 16; p++) begin
      fault_xy[p] = (all_zero_xy || ($urandom_range(0, 1) == 0)) ? 2'b00 : 2'b11;
    end
    exp_sig = 16'hFFFF;
`ifdef FPGA2_BIST_SIG_EN
    exp_sig = expected_sig();
`endif
    stop_at = (abort_at > 0) ? abort_at : rst_at;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int t = 1; t <= DONE_CYC + 2; t++) begin
      cut     = (stop_at > 0) && (t > stop_at);
      was_rst = cut && (rst_at > 0);
      exp_err = 0;
      exp_valid = 1'b0;
      exp_vec = 0;
      for (int p = 0; p < 16; p++) begin
        sc = (p + 1) * PER;
        if (mask[p] && (sc < t) && !((stop_at > 0) && (sc >= stop_at))) begin
          if (!exp_valid) exp_vec = p;
          exp_valid = 1'b1;
          exp_err++;
        end
      end
      if (exp_err > ERR_MAX) exp_err = ERR_MAX;
      if (was_rst) begin
        exp_err = 0;
        exp_valid = 1'b0;
        exp_vec = 0;
      end
      exp_pass = !cut && (t >= DONE_CYC) && (mask == 16'h0000);

      checkOutput($sformatf("busy@%0d", t), 32'(bus.busy), 32'(!cut && t <= LAST_BUSY));
      checkOutput($sformatf("done@%0d", t), 32'(bus.done), 32'(!cut && t == DONE_CYC));
      if (cut) begin
        checkOutput($sformatf("dut_in_idle@%0d", t), 32'(bus.dut_in), 32'd0);
      end else if (t <= LAST_BUSY) begin
        checkOutput($sformatf("dut_in@%0d", t), 32'(bus.dut_in), 32'((t - 1) / PER));
      end
      checkOutput($sformatf("err_cnt@%0d", t), 32'(bus.err_cnt), 32'(exp_err));
      checkOutput($sformatf("ff_valid@%0d", t), 32'(bus.first_fail_valid), 32'(exp_valid));
      if (exp_valid || was_rst) begin
        checkOutput($sformatf("ff_vec@%0d", t), 32'(bus.first_fail_vec), 32'(exp_vec));
      end
      checkOutput($sformatf("pass@%0d", t), 32'(bus.pass), 32'(exp_pass));
`ifdef FPGA2_BIST_SIG_EN
      if (was_rst || (!cut && t == 1)) begin
        checkOutput($sformatf("sig_seed@%0d", t), 32'(bus.signature), 32'h0000FFFF);
      end else if (!cut && t >= DONE_CYC) begin
        checkOutput($sformatf("sig@%0d", t), 32'(bus.signature), 32'(exp_sig));
        checkOutput($sformatf("sig_not_seed@%0d", t), 32'(bus.signature != 16'hFFFF),
                    32'(exp_sig != 16'hFFFF));
      end
`endif
      bus.start = (t == restart_at);
      bus.abort = (t == abort_at);
      rst       = (t == rst_at);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    int          abort_at;
    int          rst_at;
    int          restart_at;
    int          sel;
    logic [15:0] mask;
`ifdef FPGA2_BIST_SIG_EN
    logic [15:0] base_sig;
`endif
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    fault_mask = 16'h0000;
    flip_en    = 1'b0;
    flip_pat   = 4'd9;
    for (int p = 0; p < 16; p++) fault_xy[p] = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] checking reset values");
    checkOutput("rst_dut_in", 32'(bus.dut_in), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_pass", 32'(bus.pass), 32'd0);
    checkOutput("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    checkOutput("rst_ff_vec", 32'(bus.first_fail_vec), 32'd0);
    checkOutput("rst_ff_valid", 32'(bus.first_fail_valid), 32'd0);
`ifdef FPGA2_BIST_SIG_EN
    checkOutput("rst_sig", 32'(bus.signature), 32'h0000FFFF);
`endif
    rst = 1'b0;

    // start together with abort must leave the controller idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("start_abort_busy%0d", i), 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] fault-free run with repeated start at cycle 20");
    applyStimulus(16'h0000, 1'b0, 0, 20, 0);
    $display("[TB] single fault at pattern 5");
    applyStimulus(16'h0020, 1'b0, 0, 0, 0);
    fault_xy[5] = 2'b11;
    $display("[TB] xy stuck at 00, saturating counter");
    applyStimulus(16'hFFFF, 1'b1, 0, 0, 0);
    $display("[TB] abort at cycle 40, then rerun");
    applyStimulus(16'h0104, 1'b0, 40, 0, 0);
    applyStimulus(16'h0000, 1'b0, 0, 0, 0);
    $display("[TB] reset at cycle 50");
    applyStimulus(16'h0011, 1'b0, 0, 0, 50);

`ifdef FPGA2_BIST_SIG_EN
    $display("[TB] MISR sensitivity to a single segment flip at pattern 9");
    fault_mask = 16'h0000;
    base_sig   = expected_sig();
    flip_en    = 1'b1;
    applyStimulus(16'h0000, 1'b0, 0, 0, 0);
    checkOutput("sig_flip_differs", 32'(bus.signature != base_sig), 32'd1);
    checkOutput("sig_flip_err_cnt", 32'(bus.err_cnt), 32'd0);
    flip_en = 1'b0;
`endif

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      mask       = 16'($urandom) & 16'($urandom);
      sel        = $urandom_range(0, 2);
      abort_at   = 0;
      rst_at     = 0;
      restart_at = $urandom_range(2, LAST_BUSY);
      if (sel == 1) begin
        do abort_at = $urandom_range(1, LAST_BUSY); while (abort_at % PER == 0);
      end else if (sel == 2) begin
        rst_at = $urandom_range(1, DONE_CYC + 1);
      end
      if ((abort_at > 0 && restart_at >= abort_at) || (rst_at > 0 && restart_at >= rst_at)) begin
        restart_at = 0;
      end
      applyStimulus(mask, 1'b0, abort_at, restart_at, rst_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
